prio_grant_sequencer: RTL and testbench
=======================================

PRIO_GRANT_SEQUENCER -- requirements
Module: prio_grant_sequencer

Interface
REQ-001 The block SHALL have parameter REQ_W, default 12, giving the request vector width; only 12 is supported.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the accepted-grant counter width.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: i_req is valid this cycle.
REQ-006 The block SHALL have port o_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port i_req, input, REQ_W bits: request vector; bit 11 is highest priority.
REQ-008 The block SHALL have port o_grant_valid, output, 1 bit: o_grant_id is valid.
REQ-009 The block SHALL have port i_grant_ready, input, 1 bit: the consumer accepts the grant.
REQ-010 The block SHALL have port o_grant_id, output, 4 bits: granted request code, equal to bit position + 1 (1..12).
REQ-011 The block SHALL have port o_grant_last, output, 1 bit: the current grant is the final grant for the captured vector.
REQ-012 The block SHALL have port o_empty_cnt, output, 8 bits: saturating count of accepted all-zero vectors.
REQ-013 The block SHALL have port o_grant_cnt, output, CNT_W bits: wrapping count of accepted grants.

Function
REQ-014 The block SHALL use states IDLE, GRANT1 and GRANT2.
REQ-015 A request transfer SHALL occur when i_valid=1 and o_ready=1; o_ready SHALL be 1 only in IDLE.
REQ-016 On a transfer, the block SHALL register first = code of the highest set bit of i_req, and second = code of the highest set bit of i_req with the first bit cleared; the code for no bit SHALL be 0.
REQ-017 On a transfer with i_req=0, the block SHALL stay in IDLE, increment o_empty_cnt saturating at 255, and issue no grant.
REQ-018 On a transfer with i_req nonzero, the block SHALL go to GRANT1, and o_grant_valid SHALL be asserted on the cycle after the capture edge (latency 1).
REQ-019 In GRANT1 the outputs SHALL be o_grant_valid=1, o_grant_id=first, and o_grant_last=1 exactly when second=0.
REQ-020 In GRANT2 the outputs SHALL be o_grant_valid=1, o_grant_id=second, and o_grant_last=1.
REQ-021 A grant SHALL be accepted when o_grant_valid=1 and i_grant_ready=1; each acceptance SHALL increment o_grant_cnt, wrapping modulo 2^CNT_W.
REQ-022 On acceptance in GRANT1, the state SHALL go to IDLE if second=0 and to GRANT2 otherwise; on acceptance in GRANT2 the state SHALL go to IDLE.
REQ-023 While a grant is unaccepted, o_grant_valid, o_grant_id and o_grant_last SHALL hold stable, and i_req/i_valid SHALL be ignored.
REQ-024 o_grant_valid SHALL never be deasserted without acceptance, except by reset.
REQ-025 In IDLE, o_grant_valid SHALL be 0, and o_grant_id and o_grant_last SHALL be 0.
REQ-026 After the last grant is accepted, o_ready SHALL be 1 on the next cycle, giving one bubble between vectors.
REQ-027 All outputs SHALL be driven from registers, with no combinational path from i_req to any output.

Reset
REQ-028 Asserting i_reset SHALL immediately force IDLE, o_grant_valid=0, o_grant_id=0, o_grant_last=0, o_empty_cnt=0 and o_grant_cnt=0, with o_ready=1 after release.
REQ-029 A reset in GRANT1 or GRANT2 SHALL discard the pending grants without counting them.

Structure
REQ-030 A shared package SHALL hold the state enumeration, REQ_W=12, ID_W=4, and the NO_REQ=0 code constant.
REQ-031 A single sub-module, prio_enc_12_4, SHALL implement a combinational 12-to-4 highest-bit encoder, instantiated twice (on the raw vector and on the masked vector).

Verification
REQ-032 Capture i_req=0x805 with i_grant_ready=1 -> grants id=12 (last=0) then id=3 (last=1); o_grant_cnt=2; o_ready=1 one cycle later.
REQ-033 Capture i_req=0x001 -> single grant id=1 with last=1; state returns to IDLE; o_grant_cnt=1.
REQ-034 Capture i_req=0x000 three times -> no o_grant_valid ever; o_empty_cnt=3; capture 0x000 256 times -> o_empty_cnt holds 255.
REQ-035 Capture i_req=0xC00 with i_grant_ready=0 for 5 cycles -> id=12 held stable for 5 cycles, and a new i_req presented meanwhile is ignored; then id=11 with last=1.
REQ-036 Assert i_reset during GRANT2 of i_req=0x0A0 -> all outputs 0 asynchronously; after release, capturing 0x002 yields id=2 and last=1.
REQ-037 Preload o_grant_cnt to 0xFFFF, then accept one grant -> o_grant_cnt=0x0000.

Source files
------------

// File: rtl/prio_grant_sequencer_pkg.sv
// Shared types and constants for the priority grant sequencer.
// Codes are bit position + 1, so zero means "no request".
package prio_grant_sequencer_pkg;

    localparam int unsigned REQ_W = 12;
    localparam int unsigned ID_W  = 4;

    localparam logic [ID_W-1:0] NO_REQ = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT1 = 2'd1,
        GRANT2 = 2'd2
    } state_t;

endpackage

// File: rtl/prio_grant_sequencer_enc.sv
// Combinational 12-to-4 highest-set-bit encoder.
// Returns bit position + 1, or NO_REQ for an all-zero vector.
module prio_enc_12_4
    import prio_grant_sequencer_pkg::*;
(
    input  logic [REQ_W-1:0] req_i,
    output logic [ID_W-1:0]  code_o
);

    // Ascending scan: the last set bit seen is the highest one.
    always_comb begin
        code_o = NO_REQ;
        for (int unsigned i = 0; i < REQ_W; i++) begin
            if (req_i[i]) begin
                code_o = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/prio_grant_sequencer.sv
// Captures a request vector and issues up to two prioritised grants
// (highest and next-highest set bit) over a valid/ready handshake.
module prio_grant_sequencer #(
    parameter int unsigned REQ_W = 12,
    parameter int unsigned CNT_W = 16
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [REQ_W-1:0]                          i_req,
    output logic                                      o_grant_valid,
    input  logic                                      i_grant_ready,
    output logic [prio_grant_sequencer_pkg::ID_W-1:0] o_grant_id,
    output logic                                      o_grant_last,
    output logic [7:0]                                o_empty_cnt,
    output logic [CNT_W-1:0]                          o_grant_cnt
);

    import prio_grant_sequencer_pkg::ID_W;
    import prio_grant_sequencer_pkg::NO_REQ;
    import prio_grant_sequencer_pkg::state_t;
    import prio_grant_sequencer_pkg::IDLE;
    import prio_grant_sequencer_pkg::GRANT1;
    import prio_grant_sequencer_pkg::GRANT2;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   first_code, second_code;
    logic [ID_W-1:0]   first_q, second_q;
    logic [REQ_W-1:0]  req_masked;
    logic [7:0]        empty_cnt_q;
    logic [CNT_W-1:0]  grant_cnt_q;
    logic              capture;
    logic              accept;

    prio_enc_12_4 u_enc_first (
        .req_i  (i_req),
        .code_o (first_code)
    );

    // Clear the bit that won first place so the second encoder sees the runner-up.
    always_comb begin
        req_masked = '0;
        for (int unsigned i = 0; i < REQ_W; i++) begin
            req_masked[i] = i_req[i] && (first_code != ID_W'(i + 1));
        end
    end

    prio_enc_12_4 u_enc_second (
        .req_i  (req_masked),
        .code_o (second_code)
    );

    assign o_ready     = (state_q == IDLE);
    assign capture     = o_ready && i_valid;
    assign accept      = o_grant_valid && i_grant_ready;
    assign o_empty_cnt = empty_cnt_q;
    assign o_grant_cnt = grant_cnt_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (capture && (first_code != NO_REQ)) begin
                    state_d = GRANT1;
                end
            end
            GRANT1: begin
                if (i_grant_ready) begin
                    state_d = (second_q == NO_REQ) ? IDLE : GRANT2;
                end
            end
            GRANT2: begin
                if (i_grant_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_id    = NO_REQ;
        o_grant_last  = 1'b0;
        unique case (state_q)
            GRANT1: begin
                o_grant_valid = 1'b1;
                o_grant_id    = first_q;
                o_grant_last  = (second_q == NO_REQ);
            end
            GRANT2: begin
                o_grant_valid = 1'b1;
                o_grant_id    = second_q;
                o_grant_last  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            first_q  <= NO_REQ;
            second_q <= NO_REQ;
        end else if (capture) begin
            first_q  <= first_code;
            second_q <= second_code;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            empty_cnt_q <= '0;
        end else if (capture && (first_code == NO_REQ) && (empty_cnt_q != '1)) begin
            empty_cnt_q <= empty_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            grant_cnt_q <= '0;
        end else if (accept) begin
            grant_cnt_q <= grant_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_prio_grant_sequencer.sv
// Scoreboard bench for prio_grant_sequencer: directed vectors push their
// hand-computed grants; a negedge monitor pops and compares on each acceptance.
module tb_prio_grant_sequencer;

    typedef struct packed {
        logic [3:0] id;
        logic       last;
    } grant_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [11:0] i_req;
    logic        o_grant_valid;
    logic        i_grant_ready;
    logic [3:0]  o_grant_id;
    logic        o_grant_last;
    logic [7:0]  o_empty_cnt;
    logic [15:0] o_grant_cnt;

    grant_t      sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [15:0] exp_grant_cnt = '0;
    logic [7:0]  exp_empty_cnt = '0;

    prio_grant_sequencer #(
        .REQ_W (12),
        .CNT_W (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_req         (i_req),
        .o_grant_valid (o_grant_valid),
        .i_grant_ready (i_grant_ready),
        .o_grant_id    (o_grant_id),
        .o_grant_last  (o_grant_last),
        .o_empty_cnt   (o_empty_cnt),
        .o_grant_cnt   (o_grant_cnt)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    endfunction

    // Monitor: pops on every acceptance and checks stability while stalled.
    initial begin
        logic       pv, pr, pl;
        logic [3:0] pid;
        grant_t     e;
        pv = 1'b0; pr = 1'b0; pl = 1'b0; pid = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv = 1'b0;
                continue;
            end
            if (pv && !pr) begin
                check("stall_valid_held", 32'(o_grant_valid), 32'd1);
                check("stall_id_held",    32'(o_grant_id),    32'(pid));
                check("stall_last_held",  32'(o_grant_last),  32'(pl));
            end
            if (o_grant_valid && i_grant_ready) begin
                n_checks++;
                if (sb_q.size() > 0) begin
                    n_pass++;
                    e = sb_q.pop_front();
                    check("grant_id",   32'(o_grant_id),   32'(e.id));
                    check("grant_last", 32'(o_grant_last), 32'(e.last));
                end else begin
                    $display("FAIL unexpected_grant: actual id=%0d required no grant", o_grant_id);
                end
            end
            pv = o_grant_valid; pr = i_grant_ready; pl = o_grant_last; pid = o_grant_id;
        end
    end

    task automatic wait_ready();
        int unsigned cyc = 0;
        while (!o_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("ready_before_capture", 32'(o_ready), 32'd1);
    endtask

    // n grants expected: (id0,last0) and, if n==2, (id1,1). hold = stall cycles.
    task automatic run_vec(input logic [11:0] req, input int unsigned n, input logic [3:0] id0,
                           input logic last0, input logic [3:0] id1, input int unsigned hold);
        int unsigned cyc;
        wait_ready();
        i_valid       = 1'b1;
        i_req         = req;
        i_grant_ready = (hold == 0);
        if (n >= 1) sb_q.push_back(grant_t'{id: id0, last: last0});
        if (n == 2) sb_q.push_back(grant_t'{id: id1, last: 1'b1});
        if (n == 0 && exp_empty_cnt != 8'hFF) exp_empty_cnt = exp_empty_cnt + 8'd1;
        exp_grant_cnt = exp_grant_cnt + 16'(n);
        @(posedge clk); #1;
        check("grant_valid_latency", 32'(o_grant_valid), 32'(n > 0));
        if (hold > 0) begin
            i_req = 12'h00F;
            repeat (hold - 1) begin
                @(posedge clk); #1;
            end
        end
        i_valid       = 1'b0;
        i_grant_ready = 1'b1;
        cyc = 0;
        while (!o_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("cycles_to_ready", 32'(cyc), 32'(n));
        check("grant_cnt", 32'(o_grant_cnt), 32'(exp_grant_cnt));
        check("empty_cnt", 32'(o_empty_cnt), 32'(exp_empty_cnt));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, queue=%0d", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_req = '0; i_grant_ready = 1'b0;
        #3;
        check("rst_grant_valid", 32'(o_grant_valid), 32'd0);
        check("rst_grant_id",    32'(o_grant_id),    32'd0);
        check("rst_grant_last",  32'(o_grant_last),  32'd0);
        check("rst_empty_cnt",   32'(o_empty_cnt),   32'd0);
        check("rst_grant_cnt",   32'(o_grant_cnt),   32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", 32'(o_ready), 32'd1);

        run_vec(12'h805, 2, 4'd12, 1'b0, 4'd3,  0);
        run_vec(12'h001, 1, 4'd1,  1'b1, 4'd0,  0);
        run_vec(12'hFFF, 2, 4'd12, 1'b0, 4'd11, 0);
        run_vec(12'h800, 1, 4'd12, 1'b1, 4'd0,  0);
        run_vec(12'h401, 2, 4'd11, 1'b0, 4'd1,  0);
        repeat (3) run_vec(12'h000, 0, 4'd0, 1'b0, 4'd0, 0);
        check("empty_cnt_three", 32'(o_empty_cnt), 32'd3);
        repeat (256) run_vec(12'h000, 0, 4'd0, 1'b0, 4'd0, 0);
        check("empty_cnt_saturated", 32'(o_empty_cnt), 32'd255);
        run_vec(12'hC00, 2, 4'd12, 1'b0, 4'd11, 5);

        // Reset while the second grant of 0x0A0 is pending.
        wait_ready();
        i_valid = 1'b1; i_req = 12'h0A0; i_grant_ready = 1'b1;
        sb_q.push_back(grant_t'{id: 4'd8, last: 1'b0});
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(posedge clk); #1;
        i_grant_ready = 1'b0;
        check("g2_id",   32'(o_grant_id),   32'd6);
        check("g2_last", 32'(o_grant_last), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",     32'(o_grant_valid), 32'd0);
        check("async_rst_id",        32'(o_grant_id),    32'd0);
        check("async_rst_last",      32'(o_grant_last),  32'd0);
        check("async_rst_empty_cnt", 32'(o_empty_cnt),   32'd0);
        check("async_rst_grant_cnt", 32'(o_grant_cnt),   32'd0);
        exp_grant_cnt = '0;
        exp_empty_cnt = '0;
        #3 rst = 1'b0;
        i_grant_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(o_ready), 32'd1);
        run_vec(12'h002, 1, 4'd2, 1'b1, 4'd0, 0);

        // Preload the grant counter to its maximum and check the wrap.
        force dut.grant_cnt_q = 16'hFFFF;
        #2;
        release dut.grant_cnt_q;
        exp_grant_cnt = 16'hFFFF;
        check("grant_cnt_preload", 32'(o_grant_cnt), 32'h0000FFFF);
        run_vec(12'h001, 1, 4'd1, 1'b1, 4'd0, 0);
        check("grant_cnt_wrapped", 32'(o_grant_cnt), 32'd0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
